// File: rtl/mrx_sym_accum.sv
// mrx_sym_accum: receive-side symbol integrator.
// Sums every NSIG accepted {Q,I} samples into one complex result, scales it by
// OUT_SHIFT and narrows it to OUT_WIDTH, and emits it with the symbol index,
// a frame-end flag and a frame-sync flag.
// Optional build macro: MRX_SAT_EN -- saturating narrowing (default: wrap).
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   srst                soft realign, same effect as reset
//   in_tdata/tvalid/    input stream, {Q,I} signed samples; in_tready is low
//   tready/tlast        only during reset/srst; in_tlast marks frame end
//   out_tdata/tvalid/   result stream {Q_sum,I_sum}; out_tlast marks the last
//   tready/tlast        symbol of a frame
//   out_symb            symbol index of the held result
//   sync_ready          frame counter is all ones
//   overflow            sticky, a result was dropped under backpressure
//   align_err           sticky, in_tlast seen off the frame boundary
module mrx_sym_accum #(
    parameter int unsigned IQ_WIDTH     = 16,
    parameter int unsigned ACC_WIDTH    = 40,
    parameter int unsigned OUT_WIDTH    = 32,
    parameter int unsigned OUT_SHIFT    = 8,
    parameter int unsigned NSIG_WIDTH   = 24,
    parameter int unsigned NSIG         = 40960,
    parameter int unsigned NSYMB_WIDTH  = 16,
    parameter int unsigned NSYMB        = 512,
    parameter int unsigned RX_SYNC_BITS = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     srst,
    input  logic [2*IQ_WIDTH-1:0]    in_tdata,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    input  logic                     in_tlast,
    output logic [2*OUT_WIDTH-1:0]   out_tdata,
    output logic                     out_tvalid,
    input  logic                     out_tready,
    output logic                     out_tlast,
    output logic [NSYMB_WIDTH-1:0]   out_symb,
    output logic                     sync_ready,
    output logic                     overflow,
    output logic                     align_err
);

    localparam int unsigned EXT_W = ACC_WIDTH - IQ_WIDTH;

    logic [NSIG_WIDTH-1:0]          scount_q, scount_d;
    logic [NSYMB_WIDTH-1:0]         symb_q, symb_d;
    logic [RX_SYNC_BITS-1:0]        frame_q, frame_d;
    logic signed [ACC_WIDTH-1:0]    acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic                           ovalid_q, ovalid_d;
    logic [2*OUT_WIDTH-1:0]         odata_q, odata_d;
    logic                           olast_q, olast_d;
    logic [NSYMB_WIDTH-1:0]         osymb_q, osymb_d;
    logic                           ovf_q, ovf_d;
    logic                           aerr_q, aerr_d;

    logic                           rst_any;
    logic                           accept;
    logic                           first_samp, last_samp, last_symb, misalign;
    logic signed [ACC_WIDTH-1:0]    samp_i, samp_q, sum_i, sum_q, scl_i, scl_q;

    // Narrow a scaled sum to the output width (saturating or wrapping).
    function automatic logic [OUT_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] v);
`ifdef MRX_SAT_EN
        logic [ACC_WIDTH-OUT_WIDTH:0] top;
        top = v[ACC_WIDTH-1:OUT_WIDTH-1];
        if ((&top) || !(|top))
            return OUT_WIDTH'(v);
        else if (v[ACC_WIDTH-1])
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
        return OUT_WIDTH'(v);
`endif
    endfunction

    assign rst_any    = reset | srst;
    assign in_tready  = ~rst_any;
    assign accept     = in_tvalid & in_tready;

    assign samp_i = {{EXT_W{in_tdata[IQ_WIDTH-1]}}, in_tdata[IQ_WIDTH-1:0]};
    assign samp_q = {{EXT_W{in_tdata[2*IQ_WIDTH-1]}}, in_tdata[2*IQ_WIDTH-1:IQ_WIDTH]};

    assign first_samp = (scount_q == '0);
    assign last_samp  = (scount_q == NSIG_WIDTH'(NSIG - 1));
    assign last_symb  = (symb_q == NSYMB_WIDTH'(NSYMB - 1));
    assign misalign   = in_tlast & ~(last_samp & last_symb);

    // The first sample of a symbol loads the accumulator instead of adding.
    assign sum_i = first_samp ? samp_i : acc_i_q + samp_i;
    assign sum_q = first_samp ? samp_q : acc_q_q + samp_q;
    assign scl_i = sum_i >>> OUT_SHIFT;
    assign scl_q = sum_q >>> OUT_SHIFT;

    // Next-state: symbol/frame counting, accumulation and output hand-off.
    always_comb begin
        scount_d = scount_q;
        symb_d   = symb_q;
        frame_d  = frame_q;
        acc_i_d  = acc_i_q;
        acc_q_d  = acc_q_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        olast_d  = olast_q;
        osymb_d  = osymb_q;
        ovf_d    = ovf_q;
        aerr_d   = aerr_q;

        if (ovalid_q && out_tready)
            ovalid_d = 1'b0;

        if (accept) begin
            if (misalign) begin
                // Upstream frame marker wins: drop the partial symbol, restart at symbol 0.
                aerr_d   = 1'b1;
                scount_d = '0;
                symb_d   = '0;
                acc_i_d  = '0;
                acc_q_d  = '0;
            end else if (last_samp) begin
                scount_d = '0;
                acc_i_d  = sum_i;
                acc_q_d  = sum_q;
                if (last_symb) begin
                    symb_d  = '0;
                    frame_d = frame_q + RX_SYNC_BITS'(1);
                end else begin
                    symb_d  = symb_q + NSYMB_WIDTH'(1);
                end
                // A held, unaccepted result is kept; the new one is dropped.
                if (!ovalid_q || out_tready) begin
                    ovalid_d = 1'b1;
                    odata_d  = {narrow(scl_q), narrow(scl_i)};
                    olast_d  = last_symb;
                    osymb_d  = symb_q;
                end else begin
                    ovf_d = 1'b1;
                end
            end else begin
                scount_d = scount_q + NSIG_WIDTH'(1);
                acc_i_d  = sum_i;
                acc_q_d  = sum_q;
            end
        end
    end

    // State register with synchronous reset / soft realign.
    always_ff @(posedge clk) begin
        if (rst_any) begin
            scount_q <= '0;
            symb_q   <= '0;
            frame_q  <= '1;
            acc_i_q  <= '0;
            acc_q_q  <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            olast_q  <= 1'b0;
            osymb_q  <= '0;
            ovf_q    <= 1'b0;
            aerr_q   <= 1'b0;
        end else begin
            scount_q <= scount_d;
            symb_q   <= symb_d;
            frame_q  <= frame_d;
            acc_i_q  <= acc_i_d;
            acc_q_q  <= acc_q_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            olast_q  <= olast_d;
            osymb_q  <= osymb_d;
            ovf_q    <= ovf_d;
            aerr_q   <= aerr_d;
        end
    end

    assign out_tvalid = ovalid_q;
    assign out_tdata  = odata_q;
    assign out_tlast  = olast_q;
    assign out_symb   = osymb_q;
    assign overflow   = ovf_q;
    assign align_err  = aerr_q;
    assign sync_ready = &frame_q;

endmodule

// File: tb/tb_mrx_sym_accum.sv
// Bench for mrx_sym_accum: two instances (OUT_SHIFT 0 and 3) share one input
// stream; a queue-based symbol model predicts every output after every cycle.
module tb_mrx_sym_accum;

    localparam int NSIG  = 4;
    localparam int NSYMB = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        srst = 1'b0;
    logic [31:0] in_tdata = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tlast = 1'b0;
    logic        out_tready = 1'b1;

    logic        in_tready_a, in_tready_b;
    logic [31:0] out_tdata_a, out_tdata_b;
    logic        out_tvalid_a, out_tvalid_b, out_tlast_a, out_tlast_b;
    logic [7:0]  out_symb_a, out_symb_b;
    logic        sync_ready_a, sync_ready_b, overflow_a, overflow_b, align_err_a, align_err_b;

    always #5 clk = ~clk;

    mrx_sym_accum #(.IQ_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .OUT_SHIFT(0),
                    .NSIG_WIDTH(8), .NSIG(NSIG), .NSYMB_WIDTH(8), .NSYMB(NSYMB),
                    .RX_SYNC_BITS(3)) dut_a (
        .clk(clk), .reset(reset), .srst(srst),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready_a), .in_tlast(in_tlast),
        .out_tdata(out_tdata_a), .out_tvalid(out_tvalid_a), .out_tready(out_tready),
        .out_tlast(out_tlast_a), .out_symb(out_symb_a), .sync_ready(sync_ready_a),
        .overflow(overflow_a), .align_err(align_err_a));

    mrx_sym_accum #(.IQ_WIDTH(16), .ACC_WIDTH(24), .OUT_WIDTH(16), .OUT_SHIFT(3),
                    .NSIG_WIDTH(8), .NSIG(NSIG), .NSYMB_WIDTH(8), .NSYMB(NSYMB),
                    .RX_SYNC_BITS(3)) dut_b (
        .clk(clk), .reset(reset), .srst(srst),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready_b), .in_tlast(in_tlast),
        .out_tdata(out_tdata_b), .out_tvalid(out_tvalid_b), .out_tready(out_tready),
        .out_tlast(out_tlast_b), .out_symb(out_symb_b), .sync_ready(sync_ready_b),
        .overflow(overflow_b), .align_err(align_err_b));

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    // Reference model: samples of the open symbol, counters, and the held result.
    int          mq_i[$];
    int          mq_q[$];
    int          m_symb = 0;
    int          m_frame = 7;
    bit          m_valid = 0;
    logic [31:0] m_da = '0, m_db = '0;
    bit          m_last = 0;
    int          m_osymb = 0;
    bit          m_ovf = 0, m_aerr = 0;

    typedef struct {
        int          i;
        int          q;
        bit          ev;
        logic [31:0] ed;
        int          esymb;
        bit          elast;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Sum -> wrap to 24-bit accumulator -> arithmetic shift -> 16-bit result.
    function automatic logic [15:0] narrow(input longint s, input int sh);
        longint w;
        w = (s <<< 40) >>> 40;
        w = w >>> sh;
`ifdef MRX_SAT_EN
        if (w > 32767)  return 16'h7fff;
        if (w < -32768) return 16'h8000;
`endif
        return 16'(w);
    endfunction

    task automatic model_update(input bit rst, input bit v, input bit last,
                                input int i, input int q, input bit rdy);
        bit was;
        longint si, sq;
        if (rst) begin
            mq_i.delete(); mq_q.delete();
            m_symb = 0; m_frame = 7; m_valid = 0; m_da = '0; m_db = '0;
            m_last = 0; m_osymb = 0; m_ovf = 0; m_aerr = 0;
            return;
        end
        was = m_valid;
        if (was && rdy) m_valid = 0;
        if (!v) return;
        mq_i.push_back(i);
        mq_q.push_back(q);
        if (last && !(mq_i.size() == NSIG && m_symb == NSYMB - 1)) begin
            m_aerr = 1;
            mq_i.delete(); mq_q.delete();
            m_symb = 0;
        end else if (mq_i.size() == NSIG) begin
            si = 0; sq = 0;
            foreach (mq_i[k]) begin si += mq_i[k]; sq += mq_q[k]; end
            if (!was || rdy) begin
                m_valid = 1;
                m_da    = {narrow(sq, 0), narrow(si, 0)};
                m_db    = {narrow(sq, 3), narrow(si, 3)};
                m_last  = (m_symb == NSYMB - 1);
                m_osymb = m_symb;
            end else begin
                m_ovf = 1;
            end
            if (m_symb == NSYMB - 1) begin
                m_symb  = 0;
                m_frame = (m_frame + 1) % 8;
            end else begin
                m_symb++;
            end
            mq_i.delete(); mq_q.delete();
        end
    endtask

    task automatic compare_model();
        chk("tvalid_a", out_tvalid_a, m_valid);
        chk("tvalid_b", out_tvalid_b, m_valid);
        if (m_valid) begin
            chk("tdata_a", out_tdata_a, m_da);
            chk("tdata_b", out_tdata_b, m_db);
            chk("tlast", out_tlast_a, m_last);
            chk("symb", out_symb_a, m_osymb);
        end
        chk("overflow", overflow_a, m_ovf);
        chk("align_err", align_err_a, m_aerr);
        chk("sync_ready", sync_ready_a, m_frame == 7);
    endtask

    // One clock: drive inputs, check in_tready, advance model, check outputs.
    task automatic step(input bit v, input bit last, input int i, input int q,
                        input bit rdy, input bit sr);
        in_tvalid  = v;
        in_tlast   = last;
        in_tdata   = {16'(q), 16'(i)};
        out_tready = rdy;
        srst       = sr;
        #1;
        chk("in_tready_a", in_tready_a, !(reset || sr));
        chk("in_tready_b", in_tready_b, !(reset || sr));
        if (out_tvalid_a && rdy) xfers++;
        @(posedge clk);
        model_update(reset || sr, v, last, i, q, rdy);
        #1;
        compare_model();
    endtask

    initial begin
        int x0;
        for (int k = 0; k < 12; k++)
            tbl[k] = '{i: 100, q: -50, ev: (k % 4 == 3), ed: 32'hFF38_0190,
                       esymb: k / 4, elast: (k == 11)};

        // Reset state
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        reset = 1'b0;
        chk("rst_tvalid", out_tvalid_a, 1'b0);
        chk("rst_tdata", out_tdata_a, 32'h0);
        chk("rst_sync", sync_ready_a, 1'b1);
        chk("rst_ovf", overflow_a, 1'b0);

        // Basic integration, table-driven
        foreach (tbl[k]) begin
            step(1, 0, tbl[k].i, tbl[k].q, 1, 0);
            chk("t1_valid", out_tvalid_a, tbl[k].ev);
            if (tbl[k].ev) begin
                chk("t1_data", out_tdata_a, tbl[k].ed);
                chk("t1_symb", out_symb_a, tbl[k].esymb);
                chk("t1_last", out_tlast_a, tbl[k].elast);
            end
        end
        chk("t2_sync_after_f1", sync_ready_a, 1'b0);

        // Seven more frames bring the frame counter back to all ones
        for (int k = 0; k < 7 * 12; k++) begin
            step(1, 0, int'($urandom_range(0, 2000)) - 1000, 7, 1, 0);
            if (k == 7 * 12 - 2) chk("t2_sync_before_f8", sync_ready_a, 1'b0);
        end
        chk("t2_sync_after_f8", sync_ready_a, 1'b1);

        // Backpressure across two closes
        reset = 1'b1; step(0, 0, 0, 0, 1, 0); reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, k, 0, 0, 0);
            if (k >= 4) chk("t3_held", out_tdata_a, {16'h0, 16'd10});
        end
        chk("t3_ovf", overflow_a, 1'b1);
        x0 = xfers;
        for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 0);
        chk("t3_one_xfer", xfers - x0, 1);

        // in_tlast on the 6th sample
        reset = 1'b1; step(0, 0, 0, 0, 1, 0); reset = 1'b0;
        for (int k = 1; k <= 6; k++) step(1, k == 6, 1, 1, 1, 0);
        chk("t4_aerr", align_err_a, 1'b1);
        chk("t4_no_out", out_tvalid_a, 1'b0);
        for (int k = 0; k < 4; k++) step(1, 0, 7, -3, 1, 0);
        chk("t4_valid", out_tvalid_a, 1'b1);
        chk("t4_symb", out_symb_a, 0);
        chk("t4_data", out_tdata_a, {16'hFFF4, 16'd28});

        // Narrowing of a full-scale sum
        reset = 1'b1; step(0, 0, 0, 0, 1, 0); reset = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 0, 32767, 0, 1, 0);
`ifdef MRX_SAT_EN
        chk("t5_isum", out_tdata_a[15:0], 16'h7FFF);
`else
        chk("t5_isum", out_tdata_a[15:0], 16'hFFFC);
`endif
        chk("t5_isum_shift3", out_tdata_b[15:0], 16'd16383);

        // srst mid-symbol with a result pending
        reset = 1'b1; step(0, 0, 0, 0, 1, 0); reset = 1'b0;
        for (int k = 0; k < 4; k++) step(1, 0, 1, 1, 0, 0);
        step(1, 0, 50, 50, 0, 0);
        step(1, 0, 50, 50, 0, 0);
        chk("t6_pending", out_tvalid_a, 1'b1);
        step(1, 0, 999, 999, 0, 1);
        chk("t6_tvalid", out_tvalid_a, 1'b0);
        for (int k = 1; k <= 4; k++) step(1, 0, k, -k, 1, 0);
        chk("t6_symb", out_symb_a, 0);
        chk("t6_data", out_tdata_a, {16'hFFF6, 16'd10});

        // Randomized traffic against the model
        reset = 1'b1; step(0, 0, 0, 0, 1, 0); reset = 1'b0;
        for (int k = 0; k < 800; k++) begin
            bit v, l, r, s;
            v = ($urandom_range(0, 3) != 0);
            if (mq_i.size() == NSIG - 1 && m_symb == NSYMB - 1)
                l = $urandom_range(0, 1);
            else
                l = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 9) < 7);
            s = ($urandom_range(0, 199) == 0);
            step(v, l, int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, r, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
